// File: rtl/dmi_arbiter.sv
// Two-master Wishbone arbiter in front of the RISC-V debug module (DMI).
// Define DMI_ARB_TIMEOUT_EN to add a slave-response timeout with an ABORT state.
module dmi_arbiter #(
    parameter int DMI_ADDRW      = 9,
    parameter int DMI_DATAW      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,

    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic                   m0_we_i,
    input  logic [DMI_ADDRW-1:0]   m0_adr_i,
    input  logic [DMI_DATAW-1:0]   m0_dat_i,
    input  logic [DMI_DATAW/8-1:0] m0_sel_i,
    output logic [DMI_DATAW-1:0]   m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic                   m1_we_i,
    input  logic [DMI_ADDRW-1:0]   m1_adr_i,
    input  logic [DMI_DATAW-1:0]   m1_dat_i,
    input  logic [DMI_DATAW/8-1:0] m1_sel_i,
    output logic [DMI_DATAW-1:0]   m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [DMI_ADDRW-1:0]   s_adr_o,
    output logic [DMI_DATAW-1:0]   s_dat_o,
    output logic [DMI_DATAW/8-1:0] s_sel_o,
    input  logic [DMI_DATAW-1:0]   s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,

    output logic [1:0]             gnt_o
);

    localparam int SELW = DMI_DATAW / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmi_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

`ifdef DMI_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, ABORT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

    state_t     state_reg;
    logic       last_reg;    // 1: master 1 was granted most recently
    logic [1:0] gnt_reg;

    // Masters packed into indexable vectors so the routing below is uniform.
    logic [1:0]           m_cyc;
    logic [1:0]           m_stb;
    logic [1:0]           m_we;
    logic [DMI_ADDRW-1:0] m_adr  [2];
    logic [DMI_DATAW-1:0] m_wdat [2];
    logic [SELW-1:0]      m_sel  [2];
    logic [1:0]           m_ack;
    logic [1:0]           m_err;
    logic [DMI_DATAW-1:0] m_rdat [2];

    assign m_cyc     = {m1_cyc_i, m0_cyc_i};
    assign m_stb     = {m1_stb_i, m0_stb_i};
    assign m_we      = {m1_we_i, m0_we_i};
    assign m_adr[0]  = m0_adr_i;
    assign m_adr[1]  = m1_adr_i;
    assign m_wdat[0] = m0_dat_i;
    assign m_wdat[1] = m1_dat_i;
    assign m_sel[0]  = m0_sel_i;
    assign m_sel[1]  = m1_sel_i;

    logic [1:0] own_vec;
    logic       owner;
    logic       owning;

    assign own_vec = {state_reg == OWN1, state_reg == OWN0};
    assign owner   = (state_reg == OWN1);
    assign owning  = |own_vec;

    assign s_cyc_o = owning & m_cyc[owner];
    assign s_stb_o = owning & m_stb[owner];
    assign s_we_o  = owning & m_we[owner];
    assign s_adr_o = owning ? m_adr[owner]  : '0;
    assign s_dat_o = owning ? m_wdat[owner] : '0;
    assign s_sel_o = owning ? m_sel[owner]  : '0;

    logic timeout_hit;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_reg;
    logic        stalled;

    assign stalled     = s_stb_o & ~s_ack_i & ~s_err_i;
    // Fires during the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
    assign timeout_hit = stalled & (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tmo_cnt_reg <= '0;
        end else if (!owning || s_ack_i || s_err_i) begin
            tmo_cnt_reg <= '0;
        end else if (stalled) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Ack takes priority over a simultaneous err; nothing reaches a non-owner.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        assign m_ack[gi]  = own_vec[gi] & s_ack_i;
        assign m_err[gi]  = own_vec[gi] & ((s_err_i & ~s_ack_i) | timeout_hit);
        assign m_rdat[gi] = own_vec[gi] ? s_dat_i : '0;
    end

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_dat_o = m_rdat[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_dat_o = m_rdat[1];

    assign gnt_o = gnt_reg;

    // Grants only leave through IDLE, which gives the mandatory bubble cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            gnt_reg   <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_cyc[0] && (!m_cyc[1] || last_reg)) begin
                        state_reg <= OWN0;
                        gnt_reg   <= 2'b01;
                        last_reg  <= 1'b0;
                    end else if (m_cyc[1]) begin
                        state_reg <= OWN1;
                        gnt_reg   <= 2'b10;
                        last_reg  <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (!m_cyc[owner]) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 2'b00;
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_reg <= ABORT;
                    end
`endif
                end
`ifdef DMI_ARB_TIMEOUT_EN
                ABORT: begin
                    // gnt_reg still names the aborted owner; wait for it to let go.
                    if (!m_cyc[gnt_reg[1]]) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 2'b00;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 2'b00;
                end
            endcase
        end
    end

endmodule
